// File: rtl/sa_skew_feeder.sv
// Systolic-array left-edge feeder: streams X rows into row banks and plays them out diagonally skewed.
// Optional SA_FEED_PINGPONG_EN: two alternating banks so loading overlaps feeding.
module sa_skew_feeder #(
    parameter int DW       = 16,
    parameter int S        = 64,
    parameter int MAX_XR   = 64,
    parameter int OUT_COLS = 64
) (
    input  logic            I_CLK,
    input  logic            I_RST,
    input  logic            I_X_VLD,
    output logic            O_X_RDY,
    input  logic [S*DW-1:0] I_X,
    input  logic            I_X_LAST,
    output logic            O_FEED_RDY,
    input  logic            I_START,
    input  logic            I_SHIFT,
    output logic [S*DW-1:0] O_X,
    output logic            O_BUSY,
    output logic            O_END
);
    localparam int TW  = $clog2(MAX_XR + S + OUT_COLS);
    localparam int RIW = (MAX_XR > 1) ? $clog2(MAX_XR) : 1;
    localparam int LW  = $clog2(MAX_XR + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

    state_t          state;
    logic [S*DW-1:0] mem [2][MAX_XR];
    logic [1:0]      loaded;
    logic [1:0]      pend;
    logic [LW-1:0]   len [2];
    logic            fill_ptr;
    logic            feed_ptr;
    logic            cur;
    logic [RIW-1:0]  wr_idx;
    logic [TW-1:0]   t;
    logic [LW-1:0]   cur_len;
    logic [TW-1:0]   feed_last;
    logic [TW-1:0]   drain_last;
    logic [S*DW-1:0] x_nxt;
    logic            accept;
    logic            close;
    logic            start;

    // The bank being released is held off for the O_END cycle so a row never lands in it early.
    assign O_X_RDY    = !loaded[fill_ptr] && !(O_END && (cur == fill_ptr));
    assign O_FEED_RDY = pend[feed_ptr];
    assign O_BUSY     = (state != IDLE);
    assign accept     = I_X_VLD && O_X_RDY;
    assign close      = I_X_LAST || (wr_idx == RIW'(MAX_XR - 1));
    assign start      = I_START && (state == IDLE) && pend[feed_ptr];
    assign feed_last  = TW'(cur_len) + TW'(S - 2);
    assign drain_last = feed_last + TW'(OUT_COLS);

    // Lane k shows row (t-k) while that row exists, zero otherwise.
    for (genvar k = 0; k < S; k++) begin : g_lane
        logic [TW-1:0] d;
        logic [DW-1:0] lane;
        assign d = t - TW'(k);
        always_comb begin
            lane = '0;
            if (t >= TW'(k) && d < TW'(cur_len))
                lane = mem[cur][d[RIW-1:0]][k*DW +: DW];
        end
        assign x_nxt[k*DW +: DW] = lane;
    end

    always_ff @(posedge I_CLK) begin
        if (accept)
            mem[fill_ptr][wr_idx] <= I_X;
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state    <= IDLE;
            loaded   <= '0;
            pend     <= '0;
            len[0]   <= '0;
            len[1]   <= '0;
            fill_ptr <= 1'b0;
            feed_ptr <= 1'b0;
            cur      <= 1'b0;
            wr_idx   <= '0;
            t        <= '0;
            cur_len  <= '0;
            O_X      <= '0;
            O_END    <= 1'b0;
        end else begin
            O_END <= 1'b0;
            if (accept) begin
                if (close) begin
                    loaded[fill_ptr] <= 1'b1;
                    pend[fill_ptr]   <= 1'b1;
                    len[fill_ptr]    <= LW'(wr_idx) + LW'(1);
                    wr_idx           <= '0;
`ifdef SA_FEED_PINGPONG_EN
                    fill_ptr         <= ~fill_ptr;
`endif
                end else begin
                    wr_idx <= wr_idx + RIW'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= FEED;
                        t              <= '0;
                        cur            <= feed_ptr;
                        cur_len        <= len[feed_ptr];
                        pend[feed_ptr] <= 1'b0;
`ifdef SA_FEED_PINGPONG_EN
                        feed_ptr       <= ~feed_ptr;
`endif
                    end
                end
                FEED, DRAIN: begin
                    if (I_SHIFT) begin
                        O_X <= x_nxt;
                        t   <= t + TW'(1);
                        if (state == FEED && t == feed_last) begin
                            state <= DRAIN;
                        end else if (state == DRAIN && t == drain_last) begin
                            state       <= IDLE;
                            O_END       <= 1'b1;
                            loaded[cur] <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_skew_feeder.sv
// Randomized bench for sa_skew_feeder against a queue-based matrix model, plus directed literal checks.
module tb_sa_skew_feeder;
    localparam int DW = 16, S = 4, MAX_XR = 4, OUT_COLS = 2, W = S * DW;
`ifdef SA_FEED_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic         I_CLK = 1'b0, I_RST = 1'b1, I_X_VLD = 1'b0, I_X_LAST = 1'b0;
    logic         I_START = 1'b0, I_SHIFT = 1'b0;
    logic [W-1:0] I_X = '0;
    logic         O_X_RDY, O_FEED_RDY, O_BUSY, O_END;
    logic [W-1:0] O_X;

    sa_skew_feeder #(.DW(DW), .S(S), .MAX_XR(MAX_XR), .OUT_COLS(OUT_COLS)) dut (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_X_VLD(I_X_VLD), .O_X_RDY(O_X_RDY), .I_X(I_X),
        .I_X_LAST(I_X_LAST), .O_FEED_RDY(O_FEED_RDY), .I_START(I_START), .I_SHIFT(I_SHIFT),
        .O_X(O_X), .O_BUSY(O_BUSY), .O_END(O_END));

    always #5 I_CLK = ~I_CLK;

    int n_chk = 0, n_err = 0;
    bit chk_en = 1'b0;

    // Reference: closed matrices as a row FIFO plus a length FIFO; feeding uses the skew formula.
    logic [W-1:0] rowq[$];
    int           lenq[$];
    logic [W-1:0] frows[MAX_XR];
    int           m_occ, m_fcnt, m_t, m_len;
    bit           m_feed, m_end, m_rdy = 1'b1, m_frdy;
    logic [W-1:0] m_x = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit acc, st, sh;
        logic [W-1:0] nx;
        int idx;
        if (I_RST) begin
            rowq.delete(); lenq.delete();
            m_occ = 0; m_fcnt = 0; m_t = 0; m_len = 0;
            m_feed = 0; m_end = 0; m_rdy = 1; m_frdy = 0; m_x = '0;
            return;
        end
        acc = I_X_VLD && m_rdy;
        st  = I_START && !m_feed && lenq.size() > 0;
        sh  = I_SHIFT && m_feed;
        m_end = 0;
        if (sh) begin
            nx = '0;
            for (int k = 0; k < S; k++) begin
                idx = m_t - k;
                if (idx >= 0 && idx < m_len) nx[k*DW +: DW] = frows[idx][k*DW +: DW];
            end
            m_x = nx;
            m_t++;
            if (m_t == m_len + S - 1 + OUT_COLS) begin
                m_feed = 0; m_end = 1; m_occ--;
            end
        end
        if (acc) begin
            rowq.push_back(I_X);
            m_fcnt++;
            if (I_X_LAST || m_fcnt == MAX_XR) begin
                lenq.push_back(m_fcnt); m_fcnt = 0; m_occ++;
            end
        end
        if (st) begin
            m_len = lenq.pop_front();
            for (int i = 0; i < m_len; i++) frows[i] = rowq.pop_front();
            m_feed = 1; m_t = 0;
        end
        m_rdy  = (m_occ < NB) && !(m_end && m_occ == NB - 1);
        m_frdy = lenq.size() > 0;
    endtask

    always @(negedge I_CLK) begin
        if (chk_en) begin
            chk("o_x", O_X, m_x);
            chk("o_busy", W'(O_BUSY), W'(m_feed));
            chk("o_end", W'(O_END), W'(m_end));
            chk("o_x_rdy", W'(O_X_RDY), W'(m_rdy));
            chk("o_feed_rdy", W'(O_FEED_RDY), W'(m_frdy));
        end
    end

    task automatic step();
        @(posedge I_CLK); #1;
        model_edge();
        @(negedge I_CLK); #1;
    endtask

    task automatic step_hold();
        bit acc;
        acc = I_X_VLD && m_rdy && !I_RST;
        step();
        if (acc) begin I_X_VLD = 0; I_X_LAST = 0; end
    endtask

    task automatic push_row(input logic [W-1:0] d, input bit last);
        I_X = d; I_X_LAST = last; I_X_VLD = 1;
        for (int n = 0; n < 100 && I_X_VLD; n++) step_hold();
        if (I_X_VLD) begin
            n_chk++; n_err++;
            $display("FAIL push_row_timeout: row %h not accepted within 100 cycles", d);
            I_X_VLD = 0; I_X_LAST = 0;
        end
    endtask

    function automatic logic [W-1:0] prow(input int i);
        logic [W-1:0] r;
        for (int k = 0; k < S; k++) r[k*DW +: DW] = 16'hA000 | 16'(i << 4) | 16'(k);
        return r;
    endfunction

    initial begin
        int bi;
        // Reset state
        I_RST = 1; step(); step(); I_RST = 0; step();
        chk_en = 1;
        chk("rst_o_x", O_X, '0);
        chk("rst_rdy", W'(O_X_RDY), W'(1));
        chk("rst_frdy", W'(O_FEED_RDY), W'(0));
        chk("rst_busy", W'(O_BUSY), W'(0));

        // Ignored start and shift while nothing is loaded
        I_START = 1; step(); I_START = 0;
        chk("start_empty_busy", W'(O_BUSY), W'(0));
        I_SHIFT = 1; step(); I_SHIFT = 0;
        chk("shift_idle_o_x", O_X, '0);

        // Three rows; start arriving with the closing row is ignored
        push_row(prow(0), 0);
        push_row(prow(1), 0);
        I_X = prow(2); I_X_LAST = 1; I_X_VLD = 1; I_START = 1;
        step_hold(); I_START = 0;
        chk("start_with_close_busy", W'(O_BUSY), W'(0));
        chk("frdy_after_close", W'(O_FEED_RDY), W'(1));
        I_START = 1; step(); I_START = 0;
        chk("start_next_busy", W'(O_BUSY), W'(1));
        I_SHIFT = 1;
        for (int s = 0; s < 8; s++) begin
            step();
            if (s == 0) chk("t0_o_x", O_X, 64'h0000_0000_0000_A000);
            if (s == 3) chk("t3_o_x", O_X, 64'hA003_A012_A021_0000);
            if (s == 5) chk("t5_o_x", O_X, 64'hA023_0000_0000_0000);
            if (s >= 6) chk("drain_o_x", O_X, '0);
            if (s == 6) chk("end_not_yet", W'(O_END), W'(0));
            if (s == 7) chk("end_after_8", W'(O_END), W'(1));
        end
        I_SHIFT = 0;
        step();

        // Forced close at MAX_XR; row 4 opens the next matrix
        for (int i = 0; i < 4; i++) push_row(prow(i), 0);
        I_X = prow(4); I_X_LAST = 1; I_X_VLD = 1; I_START = 1;
        step_hold(); I_START = 0;
        I_SHIFT = 1;
        for (int s = 0; s < 9; s++) begin
            step_hold();
            if (s == 7) chk("len4_end_not_yet", W'(O_END), W'(0));
            if (s == 8) chk("len4_end_after_9", W'(O_END), W'(1));
        end
        I_SHIFT = 0;
        for (int n = 0; n < 50 && I_X_VLD; n++) step_hold();

        // Reset in the middle of a feed
        for (int n = 0; n < 50 && !m_frdy; n++) step_hold();
        I_START = 1; step(); I_START = 0;
        I_SHIFT = 1; step(); step();
        I_RST = 1; step(); I_RST = 0;
        chk("rst_feed_o_x", O_X, '0);
        chk("rst_feed_busy", W'(O_BUSY), W'(0));
        chk("rst_feed_rdy", W'(O_X_RDY), W'(1));
        chk("rst_feed_frdy", W'(O_FEED_RDY), W'(0));
        step();
        chk("shift_after_rst_o_x", O_X, '0);
        I_SHIFT = 0;

        // Matrix B offered while A feeds, start held high throughout
        push_row(prow(0), 0);
        push_row(prow(1), 1);
        I_START = 1; step();
        chk("pp_busy", W'(O_BUSY), W'(1));
`ifdef SA_FEED_PINGPONG_EN
        chk("pp_rdy_during_feed", W'(O_X_RDY), W'(1));
`else
        chk("single_rdy_during_feed", W'(O_X_RDY), W'(0));
`endif
        I_SHIFT = 1; bi = 0;
        for (int c = 0; c < 40; c++) begin
            if (!I_X_VLD && bi < 3) begin
                I_X = prow(bi); I_X_LAST = (bi == 2); I_X_VLD = 1; bi++;
            end
            step_hold();
        end
        I_START = 0; I_SHIFT = 0; I_X_VLD = 0; I_X_LAST = 0;
        I_RST = 1; step(); I_RST = 0;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if (!I_X_VLD && $urandom_range(2) == 0) begin
                I_X = {$urandom, $urandom}; I_X_LAST = ($urandom_range(2) == 0); I_X_VLD = 1;
            end
            I_START = ($urandom_range(4) == 0);
            I_SHIFT = ($urandom_range(3) != 0);
            I_RST   = ($urandom_range(499) == 0);
            step_hold();
        end
        I_X_VLD = 0; I_X_LAST = 0; I_START = 0; I_SHIFT = 0; I_RST = 0;
        step(); step();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
